// File: rtl/bcd_mult_pkg.sv
// bcd_mult_pkg: shared sizes, FSM states and BCD digit check for the decimal multiplier.
package bcd_mult_pkg;
  localparam int NDIG = 11;
  localparam int NPP  = 5;
  localparam int NOUT = 8;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic logic bcd_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: one-digit BCD adder with carry in/out.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] s;
  assign s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = s > 5'd9;
  assign sum  = cout ? s[3:0] + 4'd6 : s[3:0];
endmodule

// File: rtl/bcd_pp_accumulator.sv
// bcd_pp_accumulator: sums five BCD partial products, one per cycle, into an 8-digit product.
module bcd_pp_accumulator
  import bcd_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIG-1:0]    PP0,
  input  logic [4*NDIG-1:0]    PP1,
  input  logic [4*NDIG-1:0]    PP2,
  input  logic [4*NDIG-1:0]    PP3,
  input  logic [4*NDIG-1:0]    PP4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NOUT-1:0]    product,
  output logic                 ovf,
  output logic                 err
);
  state_t              state_q;
  logic [4*NDIG-1:0]   pp_in [NPP];
  logic [4*NDIG-1:0]   pp_q [NPP];
  logic [4*NDIG-1:0]   acc_q, sum, pp_sel;
  logic [2:0]          idx_q;
  logic                carry_q, ovf_q, err_q, pp_bad;
  logic [4*NOUT-1:0]   product_q;
  logic [NDIG:0]       c;
  assign pp_in     = '{PP0, PP1, PP2, PP3, PP4};
  assign pp_sel    = pp_q[idx_q];
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign c[0]      = 1'b0;
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_adder u_add (
      .a(acc_q[4*g+:4]), .b(pp_sel[4*g+:4]), .cin(c[g]),
      .sum(sum[4*g+:4]), .cout(c[g+1])
    );
  end
  always_comb begin
    pp_bad = 1'b0;
    for (int p = 0; p < NPP; p++)
      for (int i = 0; i < NDIG; i++)
        pp_bad = pp_bad | !bcd_valid(pp_in[p][4*i+:4]);
  end
  // carry_q remembers any wrap past digit NDIG-1 across all additions of the set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pp_q      <= '{default: '0};
      acc_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          pp_q    <= pp_in;
          acc_q   <= '0;
          idx_q   <= '0;
          carry_q <= 1'b0;
          err_q   <= pp_bad;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q   <= sum;
          idx_q   <= idx_q + 3'd1;
          carry_q <= carry_q | c[NDIG];
          if (idx_q == 3'(NPP - 1)) begin
            state_q   <= DONE;
            product_q <= err_q ? '0 : sum[4*NOUT-1:0];
            ovf_q     <= !err_q && ((|sum[4*NDIG-1:4*NOUT]) || carry_q || c[NDIG]);
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bcd_pp_accumulator.md
# bcd_pp_accumulator

Sequential reducer that consumes the five 44-bit BCD partial products (PP4..PP0) emitted by the partial product generator and sums them into the final decimal product of two 4-digit BCD operands. It adds one partial product per cycle through an 11-digit BCD carry-propagate adder. It sits directly downstream of the generator, behind a valid/ready handshake. The 8-digit product is presented on a held output with overflow and invalid-digit flags.

## Interface
Parameters:
- NDIG, 11: BCD digits per partial product and in the accumulator (width 4*NDIG).
- NPP, 5: number of partial products reduced per operation.
- NOUT, 8: BCD digits in the product output.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  partial-product set present.
- in_ready  out  1  block can accept a set.
- PP0..PP4  in  44 each  BCD partial products, pre-aligned to the product digit positions, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- product  out  32  low NOUT BCD digits of the sum.
- ovf  out  1  any of the top NDIG-NOUT sum digits nonzero, or a carry out of digit NDIG-1.
- err  out  1  a captured partial-product nibble was greater than 9.

## Operation
- FSM states are IDLE, ACCUM and DONE. Reset enters IDLE with acc=0, idx=0, product=0, ovf=0, err=0, out_valid=0 and in_ready=1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register PP0..PP4, clear acc and idx, and go to ACCUM.
  - err is computed from the captured nibbles on the same edge.
- ACCUM:
  - in_ready=0.
  - Each edge: acc <= BCD(acc + pp[idx]) mod 10^NDIG, then idx++.
  - The edge with idx=NPP-1 goes to DONE, and product/ovf are loaded from the final sum on that edge.
- DONE:
  - out_valid=1; product, ovf and err are held stable.
  - On out_ready, go to IDLE.
  - Outputs keep their values until the next accept; out_valid drops on that DONE→IDLE edge.
- BCD add: per digit, binary sum s = a+b+cin; if s>9, digit=s+6 (low 4 bits) and cout=1. Carry out of digit NDIG-1 sets the internal carry flag, which ORs into ovf.
- If err=1: product is forced to 0 and ovf to 0 in DONE. The accumulation still runs its full NPP cycles, so latency is unchanged.
- in_valid outside IDLE is ignored; no second set is buffered.
- Reset mid-ACCUM or mid-DONE: return to IDLE at once. The partial result is discarded and out_valid drops asynchronously.

## Timing
- Accept on edge k. Additions occur on edges k+1..k+5. out_valid is high from edge k+5.
- Minimum accept-to-accept spacing is 7 cycles, with out_ready held high.
- in_ready rises on the edge that consumes the result.
- No combinational path runs from in_valid or out_ready to any output other than through registered state.

## Structure
- Shared package `bcd_mult_pkg` holds:
  - NDIG, NPP, NOUT;
  - the state enum (IDLE, ACCUM, DONE);
  - the function for a BCD nibble-valid check.
- Sub-module `bcd_digit_adder`: 4-bit a, b, cin → 4-bit sum, cout. The accumulator instantiates NDIG of them in a ripple chain.
- The PP registers, the idx counter (3 bits) and the FSM live in the top module.

## Test plan
- Exact product, X=1235 × Y=3454:
  - Stimulus: PP0=44'h00000004940, PP1=44'h00000061750, PP2=44'h00000494000, PP3=44'h00003705000, PP4=0.
  - Required: out_valid 5 cycles after accept; product=32'h04265690, ovf=0, err=0.
- 9-digit sum: five PPs of 44'h00099999999 → product=32'h99999995, ovf=1.
- Wrap-around: five PPs of 44'h99999999999 → product=32'h99999995, ovf=1 (carry out of digit 10 discarded, flagged).
- Invalid digit: PP2=44'h0000000A000, others 0 → err=1, product=0 after the usual latency.
- Back-pressure and ignored input:
  - Hold out_ready=0 for 4 cycles in DONE → product stable and in_ready=0 throughout.
  - A concurrent in_valid is ignored.
  - out_ready=1 → IDLE next edge.
- Reset mid-ACCUM: assert rst after the 2nd addition → out_valid=0, in_ready=1 and product=0 immediately. A subsequent new set yields the correct result.
